// File: rtl/ahb_ecc_pkg.sv
// ============================================================================
// ahb_ecc_pkg : AHB encodings, SECDED geometry, FSM states, data extractor
// Rev 1.0
// ============================================================================
`default_nettype none

package ahb_ecc_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam int DATA_BITS   = 26;
  localparam int PARITY_BITS = 6;
  localparam int CW_BITS     = DATA_BITS + PARITY_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Data bits occupy every non-power-of-two position 3..31, in ascending order.
  function automatic logic [DATA_BITS-1:0] secded_extract(input logic [CW_BITS-1:0] cw);
    logic [DATA_BITS-1:0] data;
    logic [4:0]           j;
    data = '0;
    j    = 5'd0;
    for (int p = 1; p < CW_BITS; p++) begin
      if ((p & (p - 1)) != 0) begin
        data[j] = cw[5'(p - 1)];
        j       = j + 5'd1;
      end
    end
    return data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_secded_dec.sv
// ============================================================================
// ahb_secded_dec : combinational (32,26) SECDED decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module ahb_secded_dec
  import ahb_ecc_pkg::*;
(
  input  logic [CW_BITS-1:0]   cw_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 corr_o,
  output logic                 uncorr_o
);

  logic [4:0]         syn;
  logic               ovr;
  logic [CW_BITS-1:0] fixed;

  always_comb begin
    syn = '0;
    for (int p = 1; p < CW_BITS; p++) begin
      for (int k = 0; k < 5; k++) begin
        if (((p >> k) & 1) != 0) syn[k] = syn[k] ^ cw_i[5'(p - 1)];
      end
    end
    ovr   = ^cw_i;
    fixed = cw_i;
    // A zero syndrome with odd overall parity means only P6 flipped.
    if (ovr && (syn != 5'd0)) fixed[syn - 5'd1] = ~fixed[syn - 5'd1];
    data_o   = secded_extract(fixed);
    corr_o   = ovr;
    uncorr_o = !ovr && (syn != 5'd0);
  end

endmodule

`default_nettype wire

// File: rtl/ahb_ecc_rd_master.sv
// ============================================================================
// ahb_ecc_rd_master : AHB INCR word-burst read initiator with SECDED decode
// Optional: ECC_ERR_CNT_EN adds saturating corr/uncorr counters.  Rev 1.0
// ============================================================================
`default_nettype none

module ahb_ecc_rd_master
  import ahb_ecc_pkg::*;
#(
  parameter int MAX_BEATS = 16
`ifdef ECC_ERR_CNT_EN
  ,
  parameter int CNT_W     = 16
`endif
) (
  input  logic                          hclk,
  input  logic                          hreset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   req_addr,
  input  logic [$clog2(MAX_BEATS)-1:0]  req_len,
  output logic [31:0]                   haddr,
  output logic [1:0]                    htrans,
  output logic                          hwrite,
  output logic [2:0]                    hsize,
  output logic [2:0]                    hburst,
  output logic [63:0]                   hwdata,
  output logic                          hbusreq,
  output logic                          hlock,
  input  logic [31:0]                   hrdata,
  input  logic                          hready,
  input  logic [1:0]                    hresp,
  input  logic                          hgrant,
  output logic                          rd_valid,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_last,
  output logic                          rd_corr,
  output logic                          rd_uncorr,
  output logic                          rd_bus_err,
  output logic                          busy
`ifdef ECC_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]              corr_cnt,
  output logic [CNT_W-1:0]              uncorr_cnt
`endif
);

  localparam int LEN_W = $clog2(MAX_BEATS);

  state_e               state_q, state_d;
  logic [31:0]          haddr_q, haddr_d;
  logic [1:0]           htrans_q, htrans_d;
  logic [LEN_W-1:0]     remain_q, remain_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic                 dphase_q, dphase_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic                 rd_last_q, rd_last_d;
  logic                 rd_corr_q, rd_corr_d;
  logic                 rd_uncorr_q, rd_uncorr_d;
  logic                 rd_bus_err_q, rd_bus_err_d;

  logic [DATA_BITS-1:0] dec_data;
  logic                 dec_corr;
  logic                 dec_uncorr;
  logic                 err_resp;
  logic [31:0]          next_addr;
  logic                 addr_lsb_unused;

  ahb_secded_dec u_dec (
    .cw_i     (hrdata),
    .data_o   (dec_data),
    .corr_o   (dec_corr),
    .uncorr_o (dec_uncorr)
  );

  assign addr_lsb_unused = ^req_addr[1:0];
  assign err_resp        = dphase_q && (hresp == HRESP_ERROR);
  assign next_addr       = haddr_q + 32'd4;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= IDLE;
      haddr_q      <= '0;
      htrans_q     <= HTRANS_IDLE;
      remain_q     <= '0;
      len_q        <= '0;
      rx_cnt_q     <= '0;
      dphase_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_last_q    <= 1'b0;
      rd_corr_q    <= 1'b0;
      rd_uncorr_q  <= 1'b0;
      rd_bus_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      haddr_q      <= haddr_d;
      htrans_q     <= htrans_d;
      remain_q     <= remain_d;
      len_q        <= len_d;
      rx_cnt_q     <= rx_cnt_d;
      dphase_q     <= dphase_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_last_q    <= rd_last_d;
      rd_corr_q    <= rd_corr_d;
      rd_uncorr_q  <= rd_uncorr_d;
      rd_bus_err_q <= rd_bus_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    haddr_d      = haddr_q;
    htrans_d     = htrans_q;
    remain_d     = remain_q;
    len_d        = len_q;
    rx_cnt_d     = rx_cnt_q;
    dphase_d     = dphase_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = '0;
    rd_last_d    = 1'b0;
    rd_corr_d    = 1'b0;
    rd_uncorr_d  = 1'b0;
    rd_bus_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          haddr_d  = {req_addr[31:2], 2'b00};
          len_d    = req_len;
          rx_cnt_d = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (hgrant && hready) begin
          htrans_d = HTRANS_NONSEQ;
          remain_d = len_q;
          state_d  = XFER;
        end
      end
      XFER, DRAIN: begin
        if (err_resp) begin
          // Two-cycle ERROR: cancel the pending address now, abort when it completes.
          htrans_d = HTRANS_IDLE;
          if (hready) begin
            rd_valid_d   = 1'b1;
            rd_last_d    = 1'b1;
            rd_bus_err_d = 1'b1;
            dphase_d     = 1'b0;
            state_d      = IDLE;
          end
        end else if (hready) begin
          dphase_d = (htrans_q != HTRANS_IDLE);
          if (dphase_q) begin
            rd_valid_d  = 1'b1;
            rd_data_d   = dec_data;
            rd_corr_d   = dec_corr;
            rd_uncorr_d = dec_uncorr;
            rd_last_d   = (rx_cnt_q == len_q);
            rx_cnt_d    = rx_cnt_q + 1'b1;
          end
          if (state_q == XFER) begin
            if (remain_q != '0) begin
              haddr_d  = next_addr;
              htrans_d = (next_addr[9:0] == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
              remain_d = remain_q - 1'b1;
            end else begin
              htrans_d = HTRANS_IDLE;
              state_d  = DRAIN;
            end
          end else if (dphase_q) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign hbusreq    = (state_q == REQ) || ((state_q == XFER) && !err_resp);
  assign haddr      = haddr_q;
  assign htrans     = err_resp ? HTRANS_IDLE : htrans_q;
  assign hwrite     = 1'b0;
  assign hsize      = HSIZE_WORD;
  assign hburst     = HBURST_INCR;
  assign hwdata     = 64'd0;
  assign hlock      = 1'b0;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_last    = rd_last_q;
  assign rd_corr    = rd_corr_q;
  assign rd_uncorr  = rd_uncorr_q;
  assign rd_bus_err = rd_bus_err_q;

`ifdef ECC_ERR_CNT_EN
  logic [CNT_W-1:0] corr_cnt_q;
  logic [CNT_W-1:0] uncorr_cnt_q;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      if (rd_valid_q && rd_corr_q && (corr_cnt_q != '1))
        corr_cnt_q <= corr_cnt_q + 1'b1;
      if (rd_valid_q && rd_uncorr_q && (uncorr_cnt_q != '1))
        uncorr_cnt_q <= uncorr_cnt_q + 1'b1;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ahb_ecc_rd_master.sv
// ============================================================================
// tb_ahb_ecc_rd_master : directed self-checking bench with a small AHB slave
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ahb_ecc_rd_master;
  import ahb_ecc_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [63:0] hwdata;
  logic        hbusreq;
  logic        hlock;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;
  logic        hgrant;
  logic        rd_valid;
  logic [25:0] rd_data;
  logic        rd_last;
  logic        rd_corr;
  logic        rd_uncorr;
  logic        rd_bus_err;
  logic        busy;
`ifdef ECC_ERR_CNT_EN
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;
`endif

  always #5 hclk = ~hclk;

  ahb_ecc_rd_master dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hburst     (hburst),
    .hwdata     (hwdata),
    .hbusreq    (hbusreq),
    .hlock      (hlock),
    .hrdata     (hrdata),
    .hready     (hready),
    .hresp      (hresp),
    .hgrant     (hgrant),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .rd_corr    (rd_corr),
    .rd_uncorr  (rd_uncorr),
    .rd_bus_err (rd_bus_err),
    .busy       (busy)
`ifdef ECC_ERR_CNT_EN
    ,
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] acc_addr[$];
  logic [1:0]  acc_trans[$];
  logic [25:0] rv_data[$];
  logic        rv_last[$];
  logic        rv_corr[$];
  logic        rv_unc[$];
  logic        rv_err[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference SECDED encoder: data into non-power-of-two positions, then parity.
  function automatic logic [31:0] enc(input logic [25:0] d);
    logic [31:0] cw;
    logic        x;
    int          j;
    cw = '0;
    j  = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[5'(p - 1)] = d[5'(j)];
        j++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      x = 1'b0;
      for (int p = 1; p < 32; p++) if (((p >> k) & 1) != 0) x = x ^ cw[5'(p - 1)];
      cw[5'((1 << k) - 1)] = x;
    end
    cw[31] = ^cw[30:0];
    return cw;
  endfunction

  function automatic logic [25:0] data_of(input int i);
    return 26'h2A55A5 ^ 26'(i * 32'h0001_1111);
  endfunction

  // Issue one request and act as slave until the expected rd_valid count arrives.
  task automatic run(input logic [31:0] addr, input logic [3:0] len, input int stall_beat,
                     input int err_beat, input bit use_fixed, input logic [31:0] cw_fixed);
    int          beat, err_ph, n_exp;
    bit          dp, stalled, done, hold_pend;
    logic [1:0]  t_obs, hold_t;
    logic [31:0] hold_a;
    logic        rdy_obs;
    acc_addr.delete(); acc_trans.delete();
    rv_data.delete(); rv_last.delete(); rv_corr.delete(); rv_unc.delete(); rv_err.delete();
    n_exp = (err_beat >= 0) ? err_beat + 1 : int'(len) + 1;
    beat = 0; err_ph = 0; dp = 0; stalled = 0; done = 0; hold_pend = 0;
    hold_t = HTRANS_IDLE; hold_a = '0;
    @(posedge hclk); #1;
    req_addr = addr; req_len = len; req_valid = 1'b1;
    hready = 1'b1; hresp = HRESP_OKAY;
    @(negedge hclk);
    check_val("req_ready_idle", req_ready, 1'b1);
    @(posedge hclk); #1;
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge hclk);
      if (cyc == 0) check_val("req_ready_busy", req_ready, 1'b0);
      if (hold_pend) begin
        check_val("hold_addr", haddr, hold_a);
        check_val("hold_trans", htrans, hold_t);
        hold_pend = 0;
      end
      if (err_ph != 0 && hresp == HRESP_ERROR) check_val("err_htrans_idle", htrans, HTRANS_IDLE);
      if (hready && htrans != HTRANS_IDLE) begin
        acc_addr.push_back(haddr);
        acc_trans.push_back(htrans);
      end
      if (rd_valid) begin
        rv_data.push_back(rd_data); rv_last.push_back(rd_last);
        rv_corr.push_back(rd_corr); rv_unc.push_back(rd_uncorr); rv_err.push_back(rd_bus_err);
        if (rv_data.size() == n_exp) done = 1;
      end
      if (!hready && hresp == HRESP_OKAY) begin
        hold_pend = 1; hold_a = haddr; hold_t = htrans;
      end
      t_obs = htrans; rdy_obs = hready;
      @(posedge hclk); #1;
      if (rdy_obs) begin
        if (dp) beat++;
        dp = (t_obs != HTRANS_IDLE);
      end
      hready = 1'b1; hresp = HRESP_OKAY; hrdata = 32'h0;
      if (dp) begin
        hrdata = use_fixed ? cw_fixed : enc(data_of(beat));
        if (beat == err_beat && err_ph == 0) begin
          hready = 1'b0; hresp = HRESP_ERROR; err_ph = 1;
        end else if (beat == err_beat && err_ph == 1) begin
          hready = 1'b1; hresp = HRESP_ERROR; err_ph = 2;
        end else if (beat == stall_beat && !stalled) begin
          hready = 1'b0; stalled = 1;
        end
      end
    end
    check_val("burst_complete", done, 1'b1);
    @(negedge hclk);
    check_val("post_req_ready", req_ready, 1'b1);
    check_val("post_busy", busy, 1'b0);
    repeat (3) begin
      if (hready && htrans != HTRANS_IDLE) begin
        acc_addr.push_back(haddr); acc_trans.push_back(htrans);
      end
      @(negedge hclk);
    end
  endtask

  task automatic check_addrs(input logic [31:0] base, input int n);
    logic [31:0] a;
    check_val("n_addr", acc_addr.size(), n);
    for (int i = 0; i < n && i < acc_addr.size(); i++) begin
      a = base + 32'(4 * i);
      check_val($sformatf("addr%0d", i), acc_addr[i], a);
      check_val($sformatf("trans%0d", i), acc_trans[i],
                (i == 0 || a[9:0] == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ);
    end
  endtask

  task automatic check_beats(input int n);
    check_val("n_beats", rv_data.size(), n);
    for (int i = 0; i < n && i < rv_data.size(); i++) begin
      check_val($sformatf("data%0d", i), rv_data[i], data_of(i));
      check_val($sformatf("last%0d", i), rv_last[i], (i == n - 1));
      check_val($sformatf("corr%0d", i), rv_corr[i], 1'b0);
    end
  endtask

  task automatic check_single(input string tag, input logic [25:0] d, input logic c, input logic u);
    check_val({tag, "_nbeats"}, rv_data.size(), 1);
    check_val({tag, "_data"}, rv_data[0], d);
    check_val({tag, "_corr"}, rv_corr[0], c);
    check_val({tag, "_uncorr"}, rv_unc[0], u);
    check_val({tag, "_last"}, rv_last[0], 1'b1);
    check_val({tag, "_buserr"}, rv_err[0], 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  seen;
    logic any_act;
    hreset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
    hrdata = '0; hready = 1'b1; hresp = HRESP_OKAY; hgrant = 1'b1;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check_val("rst_htrans", htrans, HTRANS_IDLE);
    check_val("rst_haddr", haddr, 32'h0);
    check_val("rst_hbusreq", hbusreq, 1'b0);
    check_val("rst_req_ready", req_ready, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_rd_valid", rd_valid, 1'b0);
    check_val("const_ctrl", {hwrite, hsize, hburst, hlock}, {1'b0, 3'b010, 3'b001, 1'b0});
    check_val("const_hwdata", hwdata, 64'h0);
    @(posedge hclk); #1;
    hreset = 1'b0;

    run(32'h100, 4'd0, -1, -1, 1'b1, 32'h8000_0007);
    check_addrs(32'h100, 1);
    check_single("clean", 26'h1, 1'b0, 1'b0);
`ifdef ECC_ERR_CNT_EN
    check_val("cnt_clean", {corr_cnt, uncorr_cnt}, 32'h0);
`endif

    run(32'h100, 4'd0, -1, -1, 1'b1, 32'h8000_0017);
    check_single("sbe", 26'h1, 1'b1, 1'b0);
`ifdef ECC_ERR_CNT_EN
    check_val("cnt_corr", corr_cnt, 16'd1);
`endif

    run(32'h100, 4'd0, -1, -1, 1'b1, 32'h8000_0037);
    check_single("dbe", 26'h7, 1'b0, 1'b1);
`ifdef ECC_ERR_CNT_EN
    check_val("cnt_uncorr", uncorr_cnt, 16'd1);
    check_val("cnt_corr_hold", corr_cnt, 16'd1);
`endif

    run(32'h200, 4'd15, 4, -1, 1'b0, 32'h0);
    check_addrs(32'h200, 16);
    check_beats(16);

    run(32'h3F8, 4'd3, -1, -1, 1'b0, 32'h0);
    check_addrs(32'h3F8, 4);
    check_beats(4);

    run(32'h500, 4'd3, -1, 1, 1'b0, 32'h0);
    check_addrs(32'h500, 2);
    check_val("err_nbeats", rv_data.size(), 2);
    check_val("err_b0_data", rv_data[0], data_of(0));
    check_val("err_b0_flags", {rv_last[0], rv_err[0]}, 2'b00);
    check_val("err_b1_data", rv_data[1], 26'h0);
    check_val("err_b1_flags", {rv_last[1], rv_err[1]}, 2'b11);

    // Reset while beats are outstanding.
    @(posedge hclk); #1;
    req_addr = 32'h600; req_len = 4'd3; req_valid = 1'b1;
    hready = 1'b1; hresp = HRESP_OKAY; hrdata = enc(data_of(0));
    @(posedge hclk); #1;
    req_valid = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 20 && seen < 2; cyc++) begin
      @(negedge hclk);
      if (htrans != HTRANS_IDLE) seen++;
    end
    check_val("rst_mid_started", seen, 2);
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk);
    @(negedge hclk);
    check_val("rstmid_htrans", htrans, HTRANS_IDLE);
    check_val("rstmid_haddr", haddr, 32'h0);
    check_val("rstmid_ctrl", {hbusreq, req_ready, busy, rd_valid, rd_last, rd_bus_err},
              6'b010000);
    @(posedge hclk); #1;
    hreset = 1'b0;
    any_act = 1'b0;
    repeat (5) begin
      @(negedge hclk);
      any_act = any_act | rd_valid | (htrans != HTRANS_IDLE);
    end
    check_val("rstmid_quiet", any_act, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
